// File: rtl/riscy_pkg.sv
// Shared definitions for the RV32M execution units.
// Holds the datapath width and the divide-group operation encoding.
package riscy_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

endpackage

// File: rtl/div_unit.sv
// Iterative RV32M divider: one restoring step per cycle.
// Writes its result straight to the register file.
module div_unit #(
    parameter int XLEN = riscy_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    input  logic [4:0]      rd_in,
    output logic            ready,
    output logic            we3,
    output logic [4:0]      a3,
    output logic [XLEN-1:0] wd3
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   dvd_q, dvd_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              isrem_q, isrem_d;
    logic [4:0]        rd_q, rd_d;
    logic              ready_q, ready_d;
    logic              we3_q, we3_d;
    logic [4:0]        a3_q, a3_d;
    logic [XLEN-1:0]   wd3_q, wd3_d;

    riscy_pkg::div_op_t op_e;
    logic              in_signed;
    logic              in_rem;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   spec_res;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic              fit;
    logic [XLEN-1:0]   quo_nxt;
    logic [XLEN-1:0]   rem_nxt;
    logic [XLEN-1:0]   qres;
    logic [XLEN-1:0]   rres;
    logic [XLEN-1:0]   res;

    assign op_e      = riscy_pkg::div_op_t'(op);
    assign in_signed = (op_e == riscy_pkg::OP_DIV) || (op_e == riscy_pkg::OP_REM);
    assign in_rem    = (op_e == riscy_pkg::OP_REM) || (op_e == riscy_pkg::OP_REMU);
    assign a_neg     = in_signed & a_in[XLEN-1];
    assign b_neg     = in_signed & b_in[XLEN-1];

    // Restoring step: shift next dividend bit into the partial remainder.
    assign shifted = {rem_q, dvd_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign fit     = ~diff[XLEN];
    assign quo_nxt = {dvd_q[XLEN-2:0], fit};
    assign rem_nxt = fit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign qres    = qneg_q ? (~quo_nxt + 1'b1) : quo_nxt;
    assign rres    = rneg_q ? (~rem_nxt + 1'b1) : rem_nxt;
    assign res     = isrem_q ? rres : qres;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        isrem_d  = isrem_q;
        rd_d     = rd_q;
        ready_d  = ready_q;
        we3_d    = we3_q;
        a3_d     = a3_q;
        wd3_d    = wd3_q;
        spec_res = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rd_d    = rd_in;
                    isrem_d = in_rem;
                    ready_d = 1'b0;
                    if (b_in == '0) begin
                        spec_res = in_rem ? a_in : '1;
                        state_d  = DONE;
                        we3_d    = (rd_in != 5'd0);
                        a3_d     = rd_in;
                        wd3_d    = (rd_in != 5'd0) ? spec_res : '0;
                    end else if (in_signed && a_in == {1'b1, {(XLEN-1){1'b0}}}
                                 && b_in == '1) begin
                        spec_res = in_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        state_d  = DONE;
                        we3_d    = (rd_in != 5'd0);
                        a3_d     = rd_in;
                        wd3_d    = (rd_in != 5'd0) ? spec_res : '0;
                    end else begin
                        state_d = CALC;
                        cnt_d   = 6'd0;
                        dvd_d   = a_neg ? (~a_in + 1'b1) : a_in;
                        dvs_d   = b_neg ? (~b_in + 1'b1) : b_in;
                        rem_d   = '0;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                    end
                end
            end
            CALC: begin
                dvd_d = quo_nxt;
                rem_d = rem_nxt;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = DONE;
                    cnt_d   = 6'd0;
                    we3_d   = (rd_q != 5'd0);
                    a3_d    = rd_q;
                    wd3_d   = (rd_q != 5'd0) ? res : '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
                we3_d   = 1'b0;
                a3_d    = 5'd0;
                wd3_d   = '0;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                we3_d   = 1'b0;
                a3_d    = 5'd0;
                wd3_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            isrem_q <= 1'b0;
            rd_q    <= 5'd0;
            ready_q <= 1'b1;
            we3_q   <= 1'b0;
            a3_q    <= 5'd0;
            wd3_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            isrem_q <= isrem_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            we3_q   <= we3_d;
            a3_q    <= a3_d;
            wd3_q   <= wd3_d;
        end
    end

    assign ready = ready_q;
    assign we3   = we3_q;
    assign a3    = a3_q;
    assign wd3   = wd3_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, random ops
// against an arithmetic model, and start/reset corner sequences.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [4:0]  rd_in;
    logic        ready;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;

    int checks = 0;
    int errors = 0;

    div_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a_in  (a_in),
        .b_in  (b_in),
        .rd_in (rd_in),
        .ready (ready),
        .we3   (we3),
        .a3    (a3),
        .wd3   (wd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        bit is_signed = (o == 2'b00) || (o == 2'b10);
        bit is_rem    = o[1];
        if (b == 0) return is_rem ? a : 32'hFFFF_FFFF;
        if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return is_rem ? 32'h0 : 32'h8000_0000;
        if (is_signed)
            return is_rem ? 32'($signed(a) % $signed(b))
                          : 32'($signed(a) / $signed(b));
        return is_rem ? a % b : a / b;
    endfunction

    function automatic bit is_special(input logic [1:0] o,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        bit is_signed = (o == 2'b00) || (o == 2'b10);
        return (b == 0) ||
               (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Issue one op and watch it through to ready; glitch>0 pulses a
    // stray start in that busy cycle.
    task automatic run(input string nm, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp,
                       input int glitch);
        int n = 0;
        int pulses = 0;
        int wecyc = 0;
        int bad = 0;
        int lat;
        logic [31:0] got = '0;
        logic [4:0]  gota3 = '0;
        lat = is_special(o, a, b) ? 1 : 33;
        @(negedge clk);
        chk({nm, ".ready_idle"}, {31'd0, ready}, 32'd1);
        start = 1'b1;
        op = o;
        a_in = a;
        b_in = b;
        rd_in = rd;
        @(negedge clk);
        start = 1'b0;
        while (ready == 1'b0 && n < 100) begin
            n++;
            if (we3) begin
                pulses++;
                got = wd3;
                gota3 = a3;
                wecyc = n;
            end else if (a3 != 0 || wd3 != 0) begin
                bad++;
            end
            if (n == glitch) begin
                start = 1'b1;
                op = 2'b00;
                a_in = 32'd777;
                b_in = 32'd1;
                rd_in = 5'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({nm, ".busy_cycles"}, n, lat);
        chk({nm, ".we3_pulses"}, pulses, (rd != 0) ? 1 : 0);
        chk({nm, ".idle_outs"}, bad, 0);
        if (rd != 0) begin
            chk({nm, ".wd3"}, got, exp);
            chk({nm, ".a3"}, {27'd0, gota3}, {27'd0, rd});
            chk({nm, ".we3_cycle"}, wecyc, lat);
        end
    endtask

    vec_t vecs[$];

    initial begin
        rst = 1'b1;
        start = 1'b0;
        op = 2'b00;
        a_in = '0;
        b_in = '0;
        rd_in = '0;
        #1;
        chk("reset.ready", {31'd0, ready}, 32'd1);
        chk("reset.we3", {31'd0, we3}, 32'd0);
        chk("reset.a3", {27'd0, a3}, 32'd0);
        chk("reset.wd3", wd3, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        vecs.push_back('{2'b01, 32'd100, 32'd7, 5'd5, 32'd14});
        vecs.push_back('{2'b11, 32'd100, 32'd7, 5'd5, 32'd2});
        vecs.push_back('{2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFF});
        vecs.push_back('{2'b01, 32'h1234_5678, 32'd0, 5'd1, 32'hFFFF_FFFF});
        vecs.push_back('{2'b11, 32'h1234_5678, 32'd0, 5'd1, 32'h1234_5678});
        vecs.push_back('{2'b00, 32'h1234_5678, 32'd0, 5'd7, 32'hFFFF_FFFF});
        vecs.push_back('{2'b10, 32'h8765_4321, 32'd0, 5'd8, 32'h8765_4321});
        vecs.push_back('{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h8000_0000});
        vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h0});
        vecs.push_back('{2'b01, 32'hDEAD_BEEF, 32'd3, 5'd0, 32'h0});
        vecs.push_back('{2'b00, 32'd7, 32'hFFFF_FFFE, 5'd31, 32'hFFFF_FFFD});
        vecs.push_back('{2'b10, 32'd7, 32'hFFFF_FFFE, 5'd31, 32'd1});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'd1, 5'd12, 32'hFFFF_FFFF});
        vecs.push_back('{2'b01, 32'd5, 32'd9, 5'd6, 32'd0});
        vecs.push_back('{2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 5'd6, 32'h7FFF_FFFF});
        vecs.push_back('{2'b00, 32'h8000_0000, 32'd1, 5'd10, 32'h8000_0000});

        foreach (vecs[i])
            run($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].rd, vecs[i].exp, 0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o;
            logic [31:0] a, b;
            logic [4:0]  rd;
            int sel;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 15);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (sel < 6) b = b >> $urandom_range(8, 31);
            rd = 5'($urandom_range(0, 31));
            run($sformatf("rnd%0d", i), o, a, b, rd, ref_res(o, a, b), 0);
        end

        run("ignored_start", 2'b01, 32'd50, 32'd5, 5'd2, 32'd10, 10);
        run("after_ignored", 2'b11, 32'd50, 32'd7, 5'd2, 32'd1, 0);

        begin
            int pulses = 0;
            @(negedge clk);
            start = 1'b1;
            op = 2'b01;
            a_in = 32'd50;
            b_in = 32'd5;
            rd_in = 5'd2;
            @(negedge clk);
            start = 1'b0;
            repeat (10) @(negedge clk);
            chk("abort.busy", {31'd0, ready}, 32'd0);
            rst = 1'b1;
            #1;
            chk("abort.ready", {31'd0, ready}, 32'd1);
            chk("abort.we3", {31'd0, we3}, 32'd0);
            chk("abort.a3", {27'd0, a3}, 32'd0);
            chk("abort.wd3", wd3, 32'd0);
            @(negedge clk);
            rst = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (we3) pulses++;
            end
            chk("abort.no_pulse", pulses, 0);
        end
        run("post_reset", 2'b01, 32'd9, 32'd3, 5'd4, 32'd3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; accepted only on a rising edge where ready=1.
REQ-005 op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0] of RV32M divide group).
REQ-006 a_in  input  32  dividend; sampled on the accept edge only.
REQ-007 b_in  input  32  divisor; sampled on the accept edge only.
REQ-008 rd_in  input  5  destination register index; sampled on the accept edge only.
REQ-009 ready  output  1  high only in IDLE.
REQ-010 we3  output  1  register-file write enable; single-cycle pulse.
REQ-011 a3  output  5  register-file write address; valid while we3=1.
REQ-012 wd3  output  32  register-file write data; valid while we3=1.

Function
REQ-013 FSM states: IDLE, CALC, DONE; IDLE->CALC on accept (normal operands); IDLE->DONE on accept (special case); CALC->DONE after 32 iterations; DONE->IDLE unconditionally.
REQ-014 start while not in IDLE is ignored; operands, op, rd are not re-sampled.
REQ-015 Normal case: restoring division, one quotient bit per CALC cycle, 6-bit iteration counter 0..31.
REQ-016 Normal latency: DONE (we3 high) occupies the cycle after the 33rd rising edge, counting the accept edge as edge 1.
REQ-017 Special latency: DONE occupies the cycle after the accept edge.
REQ-018 Signed ops (DIV/REM) divide absolute values; quotient is negated when operand signs differ; remainder takes the dividend's sign.
REQ-019 Unsigned ops (DIVU/REMU) treat operands as unsigned 32-bit.
REQ-020 Divide by zero (b=0), special: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = a_in.
REQ-021 Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF), special: DIV result 0x80000000; REM result 0.
REQ-022 Divide by zero takes precedence over signed overflow (not simultaneously reachable; priority is fixed regardless).
REQ-023 we3 is high exactly one cycle, in DONE, and only if the latched rd != 0.
REQ-024 rd=0: full computation and latency still occur; we3 stays 0.
REQ-025 a3 = latched rd and wd3 = result during DONE; both are 0 in all other states.
REQ-026 ready drops on the accept edge; ready rises on the edge leaving DONE; back-to-back accept is allowed on the first IDLE edge.

Reset
REQ-027 rst forces IDLE, ready=1, we3=0, a3=0, wd3=0, counter=0, and clears internal operand/remainder registers, immediately and without a clock.
REQ-028 rst asserted mid-CALC or in DONE aborts the operation; no we3 pulse is produced afterwards for that operation.
REQ-029 The first start after rst deassertion is accepted normally.

Structure
REQ-030 Shared package riscy_pkg holds div_op_t (2-bit enum per REQ-005) and the XLEN constant; the FSM state enum stays local to div_unit.
REQ-031 No sub-module: single module, one sequential process for state/datapath, combinational next-state logic.

Verification
REQ-032 DIVU 100/7, rd=5 -> ready low 33 cycles, then one-cycle we3=1, a3=5, wd3=14; REMU same operands -> wd3=2.
REQ-033 DIV 0xFFFFFFF9/2 (-7/2), rd=3 -> wd3=0xFFFFFFFD; REM same operands -> wd3=0xFFFFFFFF.
REQ-034 DIVU 0x12345678/0, rd=1 -> we3 in the cycle after accept, wd3=0xFFFFFFFF; REMU same operands -> wd3=0x12345678; DIV 0x80000000/0xFFFFFFFF -> wd3=0x80000000; REM same operands -> wd3=0.
REQ-035 DIVU 0xDEADBEEF/3, rd=0 -> ready low 33 cycles, we3 never asserted, a3=0, wd3=0 throughout.
REQ-036 Start DIVU 50/5 rd=2; at CALC cycle 10 assert start with other operands -> ignored, result wd3=10, we3 pulses once.
REQ-037 Start DIVU 50/5 rd=2; pulse rst at CALC cycle 10 -> outputs zero and ready=1 immediately, no we3 pulse; then DIVU 9/3 rd=4 -> wd3=3.
